int_ctrl: RTL and testbench
===========================

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have parameter NIRQ, default 4, giving the number of interrupt request lines (2..8).
REQ-002 The block SHALL have parameter PCW, default 10, giving the program-counter width.
REQ-003 The block SHALL have parameter VBASE, default 10'h3C0, giving the vector address of line 0.
REQ-004 The block SHALL have parameter VSTRIDE, default 4, giving the vector spacing per line.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: the reset, which is synchronous and active-low (reset=0 sampled at a rising clk edge resets the block).
REQ-007 The block SHALL have port irq_in, input, NIRQ bits: the rising-edge interrupt requests.
REQ-008 The block SHALL have port mask_we, input, 1 bit: the mask write enable.
REQ-009 The block SHALL have port mask_wd, input, NIRQ bits: the mask write data; 1 enables a line.
REQ-010 The block SHALL have port pc_in, input, PCW bits: the CPU next-sequential PC, sampled on the take cycle.
REQ-011 The block SHALL have port int_ret, input, 1 bit: a one-cycle pulse from the CPU on return-from-interrupt.
REQ-012 The block SHALL have port mask_q, output, NIRQ bits: the current mask register.
REQ-013 The block SHALL have port pending, output, NIRQ bits: the latched pending requests.
REQ-014 The block SHALL have port int_take, output, 1 bit: a one-cycle pulse telling the CPU to load int_vec into the PC.
REQ-015 The block SHALL have port int_vec, output, PCW bits: the vector of the line being taken.
REQ-016 The block SHALL have port int_id, output, 3 bits: the index of the line taken or in service.
REQ-017 The block SHALL have port in_service, output, 1 bit: high while a handler runs.
REQ-018 The block SHALL have port ret_pc, output, PCW bits: the saved return PC.

Function
REQ-019 The block SHALL keep irq_prev, the irq_in sampled at the previous clk edge; an edge on line i is irq_in[i]=1 with irq_prev[i]=0.
REQ-020 An edge on line i SHALL set pending[i] at that clk edge, regardless of mask or state.
REQ-021 The block SHALL implement a three-state FSM with states IDLE, TAKE and SERV.
REQ-022 The FSM SHALL move from IDLE to TAKE when (pending & mask_q) != 0; otherwise it SHALL stay in IDLE.
REQ-023 On the IDLE->TAKE edge, the selected line SHALL be the lowest set index of (pending & mask_q), isolated as x & -x, and SHALL be latched into int_id.
REQ-024 In TAKE the block SHALL drive int_take=1 and int_vec=VBASE+int_id*VSTRIDE, truncated to PCW bits; the next edge SHALL capture pc_in into ret_pc, clear pending[int_id], and move the FSM to SERV.
REQ-025 If a new edge on line int_id coincides with its clear, set SHALL win and pending[int_id] SHALL remain 1.
REQ-026 In SERV in_service SHALL be 1; int_ret=1 SHALL move the FSM to IDLE at the next edge; ret_pc SHALL be valid throughout SERV.
REQ-027 Nesting SHALL NOT occur: pending lines wait in SERV.
REQ-028 int_ret SHALL be ignored in IDLE and TAKE.
REQ-029 mask_we=1 SHALL load mask_wd in any state, effective from the next cycle.
REQ-030 Masking a line SHALL NOT clear its pending bit.
REQ-031 int_take SHALL be 0 and int_vec SHALL be 0 outside TAKE.
REQ-032 Minimum latency SHALL be: edge sampled at clk edge k gives TAKE during cycle k+1..k+2, with int_take high for exactly one cycle.
REQ-033 After int_ret, a still-pending enabled line SHALL be taken with TAKE in the cycle right after returning to IDLE (one IDLE cycle).

Reset
REQ-034 On reset=0 at an edge, the block SHALL set state=IDLE, pending=0, mask_q=0, irq_prev=0, int_id=0 and ret_pc=0, so that int_take=0 and in_service=0; this applies from any state, including mid-TAKE or mid-SERV.
REQ-035 After reset release, a line already high SHALL count as an edge at the first non-reset clk edge.

Verification
REQ-036 The bench SHALL check: mask=4'b0110, irq_in[2] rises, pc_in=10'h025 -> one-cycle int_take, int_vec=10'h3C8, int_id=2, ret_pc=10'h025, in_service=1.
REQ-037 The bench SHALL check: irq_in[1] and irq_in[3] rise together with mask=4'b1111 -> line 1 taken first; after int_ret, line 3 is taken (int_vec=10'h3CC) after one IDLE cycle.
REQ-038 The bench SHALL check: mask=0 and irq_in[0] pulses -> pending=4'b0001 and no int_take; then mask_wd=4'b0001 is written -> int_take two cycles later.
REQ-039 The bench SHALL check: irq_in[0] re-pulses during SERV for line 0 -> no int_take until int_ret, then line 0 is taken again.
REQ-040 The bench SHALL check: reset=0 asserted during SERV -> next cycle in_service=0, pending=0, mask_q=0; int_ret pulsing in IDLE -> no state change.
REQ-041 The bench SHALL check: irq_in held high, with no new edge, across an int_ret -> no second take.

Source files
------------

// File: rtl/int_ctrl.sv
// Edge-triggered interrupt controller with a single service level.
// Latches rising edges as pending, takes the lowest enabled line, and saves the return PC.
module int_ctrl #(
  parameter int               NIRQ    = 4,
  parameter int               PCW     = 10,
  parameter logic [PCW-1:0]   VBASE   = 10'h3C0,
  parameter int               VSTRIDE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NIRQ-1:0]  irq_in,
  input  logic             mask_we,
  input  logic [NIRQ-1:0]  mask_wd,
  input  logic [PCW-1:0]   pc_in,
  input  logic             int_ret,
  output logic [NIRQ-1:0]  mask_q,
  output logic [NIRQ-1:0]  pending,
  output logic             int_take,
  output logic [PCW-1:0]   int_vec,
  output logic [2:0]       int_id,
  output logic             in_service,
  output logic [PCW-1:0]   ret_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TAKE = 2'd1,
    S_SERV = 2'd2
  } state_t;

  localparam logic [NIRQ-1:0] ONE = NIRQ'(1);

  state_t          r_state;
  state_t          w_state_nx;
  logic [NIRQ-1:0] r_irq_prev;
  logic [NIRQ-1:0] r_mask;
  logic [NIRQ-1:0] r_pending;
  logic [2:0]      r_int_id;
  logic            r_int_take;
  logic [PCW-1:0]  r_int_vec;
  logic            r_in_service;
  logic [PCW-1:0]  r_ret_pc;

  logic [NIRQ-1:0] w_edge;
  logic [NIRQ-1:0] w_req;
  logic [NIRQ-1:0] w_onehot;
  logic [NIRQ-1:0] w_clr;
  logic [2:0]      w_sel_id;
  logic            w_start;

  function automatic logic [PCW-1:0] vec_of(input logic [2:0] id);
    return VBASE + PCW'(VSTRIDE) * PCW'(id);
  endfunction

  assign w_edge   = irq_in & ~r_irq_prev;
  assign w_req    = r_pending & r_mask;
  assign w_onehot = w_req & (~w_req + ONE);
  assign w_clr    = (r_state == S_TAKE) ? (ONE << r_int_id) : '0;
  assign w_start  = (r_state == S_IDLE) && (w_state_nx == S_TAKE);

  // Encode the isolated lowest request into a line index
  always_comb begin
    w_sel_id = 3'd0;
    for (int i = 0; i < NIRQ; i++) begin
      w_sel_id = w_sel_id | (w_onehot[i] ? 3'(i) : 3'd0);
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (|w_req) w_state_nx = S_TAKE;
        else        w_state_nx = S_IDLE;
      end
      S_TAKE: w_state_nx = S_SERV;
      S_SERV: begin
        if (int_ret) w_state_nx = S_IDLE;
        else         w_state_nx = S_SERV;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Datapath and registered outputs; a new edge wins over the take-clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_irq_prev   <= '0;
      r_mask       <= '0;
      r_pending    <= '0;
      r_int_id     <= 3'd0;
      r_int_take   <= 1'b0;
      r_int_vec    <= '0;
      r_in_service <= 1'b0;
      r_ret_pc     <= '0;
    end else begin
      r_irq_prev   <= irq_in;
      r_mask       <= mask_we ? mask_wd : r_mask;
      r_pending    <= (r_pending & ~w_clr) | w_edge;
      r_int_id     <= w_start ? w_sel_id : r_int_id;
      r_int_take   <= w_start;
      r_int_vec    <= w_start ? vec_of(w_sel_id) : '0;
      r_in_service <= (w_state_nx == S_SERV);
      r_ret_pc     <= (r_state == S_TAKE) ? pc_in : r_ret_pc;
    end
  end

  assign mask_q     = r_mask;
  assign pending    = r_pending;
  assign int_take   = r_int_take;
  assign int_vec    = r_int_vec;
  assign int_id     = r_int_id;
  assign in_service = r_in_service;
  assign ret_pc     = r_ret_pc;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl with hand-computed expectations.
module tb_int_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wd;
  logic [9:0] pc_in;
  logic       int_ret;
  logic [3:0] mask_q;
  logic [3:0] pending;
  logic       int_take;
  logic [9:0] int_vec;
  logic [2:0] int_id;
  logic       in_service;
  logic [9:0] ret_pc;

  int err_cnt = 0;
  int chk_cnt = 0;

  int_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wd    (mask_wd),
    .pc_in      (pc_in),
    .int_ret    (int_ret),
    .mask_q     (mask_q),
    .pending    (pending),
    .int_take   (int_take),
    .int_vec    (int_vec),
    .int_id     (int_id),
    .in_service (in_service),
    .ret_pc     (ret_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we = 1'b1;
    mask_wd = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic pulse_ret();
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
  endtask

  initial begin
    reset = 1'b0; irq_in = 4'b0000; mask_we = 1'b0; mask_wd = 4'b0000;
    pc_in = 10'h000; int_ret = 1'b0;
    tick(); tick();
    check_eq("rst_mask",  32'(mask_q),     32'h0);
    check_eq("rst_pend",  32'(pending),    32'h0);
    check_eq("rst_take",  32'(int_take),   32'h0);
    check_eq("rst_vec",   32'(int_vec),    32'h0);
    check_eq("rst_serv",  32'(in_service), 32'h0);
    check_eq("rst_retpc", 32'(ret_pc),     32'h0);
    check_eq("rst_id",    32'(int_id),     32'h0);
    reset = 1'b1;

    // Single line 2 under mask 0110
    write_mask(4'b0110);
    check_eq("a_mask", 32'(mask_q), 32'h6);
    irq_in = 4'b0100; pc_in = 10'h025;
    tick();
    check_eq("a_pend",  32'(pending),  32'h4);
    check_eq("a_take0", 32'(int_take), 32'h0);
    tick();
    check_eq("a_take",  32'(int_take), 32'h1);
    check_eq("a_vec",   32'(int_vec),  32'h3C8);
    check_eq("a_id",    32'(int_id),   32'h2);
    tick();
    check_eq("a_take_1cyc", 32'(int_take),   32'h0);
    check_eq("a_vec_off",   32'(int_vec),    32'h0);
    check_eq("a_serv",      32'(in_service), 32'h1);
    check_eq("a_retpc",     32'(ret_pc),     32'h025);
    check_eq("a_pendclr",   32'(pending),    32'h0);
    pc_in = 10'h111;
    tick();
    check_eq("a_retpc_hold", 32'(ret_pc), 32'h025);
    pulse_ret();
    check_eq("a_idle", 32'(in_service), 32'h0);
    tick(); tick();
    check_eq("a_held_notake", 32'(int_take), 32'h0);
    irq_in = 4'b0000;

    // Lines 1 and 3 together: 1 first, then 3 after one idle cycle
    write_mask(4'b1111);
    irq_in = 4'b1010; pc_in = 10'h050;
    tick();
    check_eq("b_pend", 32'(pending), 32'hA);
    tick();
    check_eq("b_take1", 32'(int_take), 32'h1);
    check_eq("b_id1",   32'(int_id),   32'h1);
    check_eq("b_vec1",  32'(int_vec),  32'h3C4);
    tick();
    irq_in = 4'b0000;
    check_eq("b_serv",  32'(in_service), 32'h1);
    check_eq("b_pend3", 32'(pending),    32'h8);
    tick();
    check_eq("b_nonest", 32'(int_take), 32'h0);
    pulse_ret();
    check_eq("b_idle_take", 32'(int_take),   32'h0);
    check_eq("b_idle_serv", 32'(in_service), 32'h0);
    tick();
    check_eq("b_take3", 32'(int_take), 32'h1);
    check_eq("b_vec3",  32'(int_vec),  32'h3CC);
    check_eq("b_id3",   32'(int_id),   32'h3);
    tick();
    check_eq("b_pend0", 32'(pending), 32'h0);
    pulse_ret();

    // Masked line stays pending; enabling it triggers a take
    write_mask(4'b0000);
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    tick(); tick();
    check_eq("c_pend",   32'(pending),  32'h1);
    check_eq("c_notake", 32'(int_take), 32'h0);
    pc_in = 10'h0AA;
    write_mask(4'b0001);
    check_eq("c_take_early", 32'(int_take), 32'h0);
    tick();
    check_eq("c_take", 32'(int_take), 32'h1);
    check_eq("c_vec",  32'(int_vec),  32'h3C0);
    check_eq("c_id",   32'(int_id),   32'h0);
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    check_eq("c_set_wins", 32'(pending), 32'h1);
    check_eq("c_retpc",    32'(ret_pc),  32'h0AA);
    pulse_ret();
    tick();
    check_eq("c_retake", 32'(int_take), 32'h1);
    tick();
    check_eq("c_pend0", 32'(pending), 32'h0);

    // Re-pulse of line 0 while servicing line 0
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    check_eq("d_pend", 32'(pending), 32'h1);
    tick(); tick();
    check_eq("d_notake", 32'(int_take),   32'h0);
    check_eq("d_serv",   32'(in_service), 32'h1);
    pc_in = 10'h1F0;
    pulse_ret();
    check_eq("d_idle", 32'(int_take), 32'h0);
    tick();
    check_eq("d_take", 32'(int_take), 32'h1);
    check_eq("d_id",   32'(int_id),   32'h0);
    tick();
    check_eq("d_serv2", 32'(in_service), 32'h1);
    check_eq("d_retpc", 32'(ret_pc),     32'h1F0);

    // Reset during service, then int_ret in idle
    irq_in = 4'b0010;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    irq_in = 4'b0000;
    check_eq("e_serv",  32'(in_service), 32'h0);
    check_eq("e_pend",  32'(pending),    32'h0);
    check_eq("e_mask",  32'(mask_q),     32'h0);
    check_eq("e_retpc", 32'(ret_pc),     32'h0);
    pulse_ret();
    check_eq("e_ret_idle_serv", 32'(in_service), 32'h0);
    check_eq("e_ret_idle_take", 32'(int_take),   32'h0);

    // Held-high line across int_ret: no second take
    write_mask(4'b0001);
    irq_in = 4'b0001;
    tick(); tick();
    check_eq("g_take", 32'(int_take), 32'h1);
    tick();
    pulse_ret();
    tick(); tick();
    check_eq("g_no2nd",  32'(int_take),   32'h0);
    check_eq("g_idle",   32'(in_service), 32'h0);
    check_eq("g_pend",   32'(pending),    32'h0);

    // Line already high through reset counts as an edge after release
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_eq("g_rst_pend", 32'(pending), 32'h0);
    tick();
    check_eq("g_post_rst_edge", 32'(pending), 32'h1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
